// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The byte merge is used by both the write path and the read-port bypass.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_t;

    localparam int unsigned BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: forces zero while busy or for the zero register,
// and otherwise forwards byte-merged write data when the address matches the write.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  i_busy,
    input  logic [ADDR_W-1:0]     i_raddr,
    input  logic [DATA_W-1:0]     i_mem_data,
    input  logic                  i_wr_act,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wbe,
    output logic [DATA_W-1:0]     o_rdata
);

    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_merged;

    always_comb begin
        w_merged = '0;
        w_zero   = i_busy || ((ZERO_REG != 0) && (i_raddr == '0));
        w_hit    = (BYPASS != 0) && i_wr_act && (i_raddr == i_waddr);
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            w_merged[8*i +: 8] = byte_merge(i_mem_data[8*i +: 8], i_wdata[8*i +: 8], i_wbe[i]);
        end
        if (w_zero) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = w_merged;
        end else begin
            o_rdata = i_mem_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write port and a sequential
// clear engine that zeroes one entry per cycle after reset while Busy is high.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_RD*ADDR_W-1:0]   RAddr,
    output logic [NUM_RD*DATA_W-1:0]   RData,
    input  logic [ADDR_W-1:0]          WAddr,
    input  logic [DATA_W-1:0]          WData,
    input  logic [DATA_W/8-1:0]        WByteEn,
    input  logic                       RegWr,
    output logic                       Busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_busy;

    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              w_busy_nxt;
    logic              w_wr_en;
    logic              w_wr_act;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_wr_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_busy_nxt    = r_busy;
        case (r_state)
            CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                w_busy_nxt    = 1'b1;
                if (r_clr_idx == '1) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            IDLE: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = CLEAR;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    assign Busy     = r_busy;
    assign w_wr_act = RegWr && !r_busy;
    assign w_wr_old = r_mem[WAddr];

    always_comb begin
        w_wr_data = '0;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            w_wr_data[8*i +: 8] = byte_merge(w_wr_old[8*i +: 8], WData[8*i +: 8], WByteEn[i]);
        end
        w_wr_en = RegWr && (r_state == IDLE) && (WByteEn != '0)
                  && !((ZERO_REG != 0) && (WAddr == '0));
    end

    // Clear engine and write port share the array; the clear always wins while CLEAR.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_en) begin
                r_mem[WAddr] <= w_wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [DATA_W-1:0] w_mem_rd;
        assign w_mem_rd = r_mem[RAddr[g*ADDR_W +: ADDR_W]];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .i_busy     (r_busy),
            .i_raddr    (RAddr[g*ADDR_W +: ADDR_W]),
            .i_mem_data (w_mem_rd),
            .i_wr_act   (w_wr_act),
            .i_waddr    (WAddr),
            .i_wdata    (WData),
            .i_wbe      (WByteEn),
            .o_rdata    (RData[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] raddr = '0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe   = '0;
  logic        regwr = 1'b0;
  logic [95:0] rdata_a, rdata_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb [$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .Clk(clk), .Reset(rst), .RAddr(raddr), .RData(rdata_a), .WAddr(waddr),
    .WData(wdata), .WByteEn(wbe), .RegWr(regwr), .Busy(busy_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .Clk(clk), .Reset(rst), .RAddr(raddr), .RData(rdata_b), .WAddr(waddr),
    .WData(wdata), .WByteEn(wbe), .RegWr(regwr), .Busy(busy_b)
  );

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_t         e;
      logic [31:0] act;
      e = sb.pop_front();
      if (e.kind == 1) act = {31'b0, (e.dut == 0) ? busy_a : busy_b};
      else act = (e.dut == 0) ? rdata_a[e.port*32 +: 32] : rdata_b[e.port*32 +: 32];
      n_checks++;
      if (act !== e.exp) begin
        n_fails++;
        $display("FAIL %s dut%0d port%0d: got %h expected %h", e.name, e.dut, e.port, act, e.exp);
      end
    end
  end

  task automatic check_now(input logic [95:0] act, input logic [95:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input int dut, input int port, input logic [31:0] exp, input string name);
    sb_t e;
    e.dut = dut; e.kind = 0; e.port = port; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_busy(input logic b, input string name);
    sb_t e;
    for (int unsigned d = 0; d < 2; d++) begin
      e.dut = d; e.kind = 1; e.port = 0; e.exp = {31'b0, b}; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    raddr = {a2, a1, a0};
  endtask

  initial begin
    logic        timed_out;
    int unsigned wait_cnt;

    cycle();
    check_now({94'b0, busy_b, busy_a}, {94'b0, 2'b11}, "reset_state_busy");
    check_now(rdata_a, '0, "reset_state_rdata_a");
    check_now(rdata_b, '0, "reset_state_rdata_b");
    exp_busy(1'b1, "busy_in_reset");
    rst = 1'b0;
    set_raddr(5'd3, 5'd4, 5'd5);
    for (int unsigned e = 1; e <= 32; e++) begin
      cycle();
      exp_busy((e < 32), "busy_clear_count");
      if (e == 1) exp_rd(0, 0, 32'h0, "rd_zero_while_busy");
    end
    for (int unsigned a = 0; a < 32; a++) begin
      set_raddr(a[4:0], a[4:0], a[4:0]);
      for (int unsigned p = 0; p < 3; p++) begin
        exp_rd(0, p, 32'h0, "cleared_entry");
        exp_rd(1, p, 32'h0, "cleared_entry");
      end
      cycle();
    end

    regwr = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF;
    set_raddr(5'd1, 5'd1, 5'd1);
    cycle();
    regwr = 1'b0; set_raddr(5'd5, 5'd2, 5'd2);
    exp_rd(0, 0, 32'hDEADBEEF, "full_write");
    exp_rd(1, 0, 32'hDEADBEEF, "full_write");
    cycle();

    regwr = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wbe = 4'b0101;
    set_raddr(5'd5, 5'd5, 5'd5);
    exp_rd(0, 1, 32'hDE22BE44, "bypass_merge");
    exp_rd(1, 1, 32'hDEADBEEF, "nobypass_old");
    cycle();
    regwr = 1'b0;
    exp_rd(0, 0, 32'hDE22BE44, "partial_write");
    exp_rd(1, 0, 32'hDE22BE44, "partial_write");
    cycle();

    regwr = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    set_raddr(5'd0, 5'd0, 5'd0);
    exp_rd(0, 0, 32'h0, "zero_reg_same");
    exp_rd(1, 0, 32'h0, "zero_reg_same");
    cycle();
    regwr = 1'b1; waddr = 5'd5; wdata = 32'h0; wbe = 4'h0;
    exp_rd(0, 0, 32'h0, "zero_reg_after");
    exp_rd(1, 0, 32'h0, "zero_reg_after");
    set_raddr(5'd0, 5'd5, 5'd5);
    exp_rd(0, 1, 32'hDE22BE44, "be0_bypass");
    cycle();
    regwr = 1'b0;
    exp_rd(0, 1, 32'hDE22BE44, "be0_no_write");
    exp_rd(1, 1, 32'hDE22BE44, "be0_no_write");
    cycle();

    regwr = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; wbe = 4'b1001;
    set_raddr(5'd9, 5'd9, 5'd9);
    for (int unsigned p = 0; p < 3; p++) begin
      exp_rd(0, p, 32'hCA00000D, "multi_port_bypass");
      exp_rd(1, p, 32'h0, "multi_port_nobypass");
    end
    cycle();
    regwr = 1'b0;
    for (int unsigned p = 0; p < 3; p++) begin
      exp_rd(0, p, 32'hCA00000D, "multi_port_after");
      exp_rd(1, p, 32'hCA00000D, "multi_port_after");
    end
    cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    regwr = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; wbe = 4'hF;
    set_raddr(5'd5, 5'd9, 5'd7);
    for (int unsigned e = 1; e <= 9; e++) begin
      cycle();
      exp_busy(1'b1, "busy_before_rerst");
    end
    rst = 1'b1;
    cycle();
    exp_busy(1'b1, "busy_at_rerst");
    rst = 1'b0;
    for (int unsigned e = 1; e <= 32; e++) begin
      cycle();
      if (e == 32) regwr = 1'b0;
      exp_busy((e < 32), "busy_after_rerst");
      if (e == 5) exp_rd(0, 0, 32'h0, "rd_zero_busy_restart");
    end
    for (int unsigned p = 0; p < 3; p++) begin
      exp_rd(0, p, 32'h0, "recleared");
      exp_rd(1, p, 32'h0, "recleared");
    end

    timed_out = 1'b0;
    wait_cnt  = 0;
    while ((busy_a || busy_b) && !timed_out) begin
      cycle();
      wait_cnt++;
      if (wait_cnt >= 40) timed_out = 1'b1;
    end
    check_now({95'b0, timed_out}, '0, "busy_wait_expired");
    check_now({64'b0, wait_cnt}, '0, "busy_low_after_32_edges");
    cycle();

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
